program_ingress: RTL
====================

Name: program_ingress

Overview:
- Front-end stage directly upstream of the placement core.
- Samples the program dimension stream (height_i/width_i), which holds each value for 4 clock cycles, once per slot.
- Classifies each sample as idle, invalid or valid; drops and counts invalid samples; buffers valid requests in a small FIFO.
- Presents buffered requests to the placer over a valid/ready handshake, so placer stalls never lose a program.

Parameters:
- DIM_W, 5, width of height/width fields
- SLOT_LEN, 4, clock cycles per input slot
- SAMPLE_PHASE, 1, slot phase (0..SLOT_LEN-1) at which inputs are sampled
- MIN_DIM, 4, smallest legal height/width
- MAX_DIM, 16, largest legal height/width
- FIFO_DEPTH, 4, request buffer entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- height_i  in  DIM_W  program height, held for one slot
- width_i  in  DIM_W  program width, held for one slot
- req_valid_o  out  1  FIFO head holds a valid request
- req_ready_i  in  1  placer accepts the head request this cycle
- req_height_o  out  DIM_W  head request height
- req_width_o  out  DIM_W  head request width
- slot_phase_o  out  clog2(SLOT_LEN)  current slot phase
- level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- drop_cnt_o  out  4  invalid samples, saturating
- overflow_o  out  1  sticky: valid sample lost because FIFO was full

Behaviour:
- Reset: rst is synchronous, active-low; clock is clk.
- Reset values: all outputs 0, FIFO empty, phase 0.
- Reset asserted mid-operation flushes FIFO contents and clears drop_cnt_o and overflow_o on that edge.
- Phase counter: increments every cycle after reset release, wraps SLOT_LEN-1 -> 0.
  - The first edge with rst=1 moves phase 0 -> 1.
- Sampling: on the edge where phase==SAMPLE_PHASE, classify {height_i, width_i}:
  - IDLE: both 0. No action, no count.
  - INVALID: either field 0 (other nonzero), or either field outside [MIN_DIM, MAX_DIM]. drop_cnt_o += 1, saturating at 15.
  - VALID: push {height, width} into the FIFO.
- Push when FIFO is full:
  - If a pop occurs on the same edge, the push is accepted and level is unchanged.
  - Otherwise the sample is discarded, overflow_o is set, and drop_cnt_o is not incremented.
- FIFO:
  - First-word-fall-through.
  - req_valid_o = (level_o != 0).
  - req_height_o/req_width_o show the head entry and are 0 when empty.
  - Pop on an edge where req_valid_o and req_ready_i are both 1.
  - req_ready_i is ignored when empty; no underflow.
- Latency: a valid sample pushed at edge N gives req_valid_o=1 with its data after edge N, provided the FIFO was empty (1 cycle).
- Simultaneous push and pop on a non-full FIFO: level unchanged, head advances.
- Pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.
- No state machine beyond the phase counter and FIFO. All outputs are registered except req_valid_o and the head data, which come from registered state.

Decomposition:
- Shared package program_pkg:
  - DIM_W, MIN_DIM, MAX_DIM, SLOT_LEN
  - typedef prog_req_t {height, width}
  - sample class enum {IDLE, INVALID, VALID}
  - classify function
- One sub-module: req_fifo, a parameterised FWFT FIFO with level output.
  - Reusable for the placer's output path.

Test Plan:
- Reset, then hold 0/0 for 10 slots -> req_valid_o=0, drop_cnt_o=0, slot_phase_o cycles 0,1,2,3.
- Drive 5/7 for one slot with req_ready_i=1 -> req_valid_o high for exactly 1 cycle, beginning the cycle after the phase-1 edge; head=5/7; level returns to 0.
- Drive 3/8, 0/9, 17/4, then 16/16 -> drop_cnt_o=3; only 16/16 is delivered.
- req_ready_i=0 while driving 5 valid programs 4/4..8/8 ->
  - level_o=4, overflow_o=1 after the 5th.
  - Raising ready delivers 4/4,5/5,6/6,7/7 in order.
- FIFO full, 9/9 sampled on the same edge as a pop -> 9/9 accepted, overflow_o stays 0, level_o stays 4.
- Assert rst for 1 cycle with level_o=3 and drop_cnt_o=2 -> next cycle level_o=0, drop_cnt_o=0, req_valid_o=0, slot_phase_o=0.

Source files
------------

// File: rtl/program_pkg.sv
// Shared types and helpers for the program ingress path and the placer front-end.
package program_pkg;

    localparam int DIM_W    = 5;
    localparam int MIN_DIM  = 4;
    localparam int MAX_DIM  = 16;
    localparam int SLOT_LEN = 4;

    typedef struct packed {
        logic [DIM_W-1:0] height;
        logic [DIM_W-1:0] width;
    } prog_req_t;

    typedef enum logic [1:0] {
        CLS_IDLE    = 2'd0,
        CLS_INVALID = 2'd1,
        CLS_VALID   = 2'd2
    } sample_class_e;

    // True when a single dimension lies inside the legal inclusive range.
    function automatic logic dim_in_range(
        input logic [DIM_W-1:0] dim,
        input int               min_dim,
        input int               max_dim
    );
        return (int'(dim) >= min_dim) && (int'(dim) <= max_dim);
    endfunction

    // An all-zero pair is the idle pattern; anything else must have both
    // fields in range to count as a program request.
    function automatic sample_class_e classify(
        input logic [DIM_W-1:0] height,
        input logic [DIM_W-1:0] width,
        input int               min_dim,
        input int               max_dim
    );
        if ((height == '0) && (width == '0)) begin
            return CLS_IDLE;
        end
        if (dim_in_range(height, min_dim, max_dim) && dim_in_range(width, min_dim, max_dim)) begin
            return CLS_VALID;
        end
        return CLS_INVALID;
    endfunction

endpackage

// File: rtl/program_ingress_fifo.sv
// First-word-fall-through request FIFO with occupancy output. A push into a
// full FIFO is accepted only when a pop happens on the same edge; the caller
// sees the outcome on push_accept_o. DEPTH must be a power of two (>= 2) so
// the pointers wrap naturally.
module req_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      push_data_i,
    output logic                   push_accept_o,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [DATA_W-1:0]      head_data_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              pop_ok;
    logic              push_ok;
    logic              full;

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        full     = (level_q == LVL_FULL);
        pop_ok   = pop_i && (level_q != '0);
        push_ok  = push_i && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; a reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until the level covers them.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign push_accept_o = push_ok;
    assign valid_o       = (level_q != '0);
    assign head_data_o   = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o       = level_q;

endmodule

// File: rtl/program_ingress.sv
// Ingress stage ahead of the placement core: samples the slow dimension
// stream once per slot, drops and counts malformed programs, and buffers
// legal requests so placer stalls never lose a program.
module program_ingress
    import program_pkg::*;
#(
    parameter int SLOT_LEN_P   = SLOT_LEN,
    parameter int SAMPLE_PHASE = 1,
    parameter int MIN_DIM_P    = MIN_DIM,
    parameter int MAX_DIM_P    = MAX_DIM,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIM_W-1:0]              height_i,
    input  logic [DIM_W-1:0]              width_i,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    output logic [DIM_W-1:0]              req_height_o,
    output logic [DIM_W-1:0]              req_width_o,
    output logic [$clog2(SLOT_LEN_P)-1:0] slot_phase_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic [3:0]                    drop_cnt_o,
    output logic                          overflow_o
);

    localparam int PHASE_W = $clog2(SLOT_LEN_P);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(SLOT_LEN_P - 1);
    localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_PHASE);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]         drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    sample_class_e      sample_cls;
    logic               sample_en;
    logic               push;
    logic               pop;
    logic               push_accept;
    logic               fifo_valid;
    prog_req_t          push_req;
    prog_req_t          head_req;

    // Slot phase advances every cycle and wraps at the end of the slot.
    always_comb begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_q == PHASE_LAST) begin
            phase_d = '0;
        end
    end

    // Classify the held input once per slot and update drop/overflow status.
    always_comb begin
        sample_en  = (phase_q == PHASE_SAMPLE);
        sample_cls = classify(height_i, width_i, MIN_DIM_P, MAX_DIM_P);
        push       = sample_en && (sample_cls == CLS_VALID);
        push_req   = '{height: height_i, width: width_i};
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (sample_en && (sample_cls == CLS_INVALID) && (drop_cnt_q != 4'hF)) begin
            drop_cnt_d = drop_cnt_q + 4'd1;
        end
        // A legal program lost to a full buffer is flagged, not counted as a drop.
        if (push && !push_accept) begin
            overflow_d = 1'b1;
        end
    end

    // Status registers; a reset at any time returns to the idle state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign pop = fifo_valid && req_ready_i;

    req_fifo #(
        .DATA_W ($bits(prog_req_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_req_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (push),
        .push_data_i   (push_req),
        .push_accept_o (push_accept),
        .pop_i         (pop),
        .valid_o       (fifo_valid),
        .head_data_o   (head_req),
        .level_o       (level_o)
    );

    assign req_valid_o  = fifo_valid;
    assign req_height_o = head_req.height;
    assign req_width_o  = head_req.width;
    assign slot_phase_o = phase_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign overflow_o   = overflow_q;

endmodule
